// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD display controller: double-dabble conversion of a calculator result,
// then time-multiplexed drive of a 4-digit common-segment 7-segment display.
module bcd_display_ctrl #(
   parameter int IN_W     = 14,
   parameter int SCAN_DIV = 100000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [IN_W-1:0] value,
   input  logic            lz_blank,
   output logic            busy,
   output logic            done,
   output logic            ovf,
   output logic [3:0]      digit_thou,
   output logic [3:0]      digit_hund,
   output logic [3:0]      digit_tens,
   output logic [3:0]      digit_ones,
   output logic [3:0]      an,
   output logic [6:0]      seg
);

   localparam int          CNT_W = $clog2(IN_W + 1);
   localparam int          PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [15:0] DASH4 = 16'hAAAA;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [IN_W-1:0] r_bin;
   logic [15:0]     r_bcd;
   logic [CNT_W-1:0] r_cnt;
   logic            r_ovf_flag;
   logic [15:0]     r_digits;
   logic            r_ovf;

   logic [PS_W-1:0] r_presc;
   logic [1:0]      r_idx;
   logic [3:0]      r_an;
   logic [6:0]      r_seg;

   logic            w_val_ovf;
   logic            w_last_shift;
   logic [15:0]     w_bcd_adj;
   logic [3:0]      w_cur;
   logic            w_upper_zero;
   logic            w_blank;
   logic [3:0]      w_an_nxt;
   logic [6:0]      w_seg_nxt;

   function automatic logic [15:0] f_add3(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [6:0] f_seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0111111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   assign w_val_ovf    = 32'(value) > 32'd9999;
   assign w_last_shift = (r_cnt == CNT_W'(1));
   assign w_bcd_adj    = f_add3(r_bcd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_nxt = w_val_ovf ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            busy = 1'b1;
            if (w_last_shift) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Conversion datapath; committed digits change only in DONE so the display never sees partial BCD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_ovf_flag <= 1'b0;
         r_digits   <= '0;
         r_ovf      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_bin      <= value;
                  r_bcd      <= '0;
                  r_cnt      <= CNT_W'(IN_W);
                  r_ovf_flag <= w_val_ovf;
               end
            end
            S_SHIFT: begin
               {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
               r_cnt          <= r_cnt - CNT_W'(1);
            end
            S_DONE: begin
               r_digits <= r_ovf_flag ? DASH4 : r_bcd;
               r_ovf    <= r_ovf_flag;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_cur        = r_digits[3:0];
      w_upper_zero = 1'b0;
      case (r_idx)
         2'd0: w_cur = r_digits[3:0];
         2'd1: begin
            w_cur        = r_digits[7:4];
            w_upper_zero = (r_digits[15:4] == 12'd0);
         end
         2'd2: begin
            w_cur        = r_digits[11:8];
            w_upper_zero = (r_digits[15:8] == 8'd0);
         end
         default: begin
            w_cur        = r_digits[15:12];
            w_upper_zero = (r_digits[15:12] == 4'd0);
         end
      endcase
      // Ones digit never blanks: w_upper_zero stays 0 for slot 0
      w_blank   = lz_blank && !r_ovf && w_upper_zero;
      w_an_nxt  = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
      w_seg_nxt = w_blank ? 7'b1111111 : f_seg7(w_cur);
   end

   // Free-running scanner, independent of the conversion FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= 2'd0;
         r_an    <= 4'b1111;
         r_seg   <= 7'b1111111;
      end else begin
         if (r_presc == PS_W'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
         end else begin
            r_presc <= r_presc + PS_W'(1);
         end
         r_an  <= w_an_nxt;
         r_seg <= w_seg_nxt;
      end
   end

   assign ovf        = r_ovf;
   assign digit_thou = r_digits[15:12];
   assign digit_hund = r_digits[11:8];
   assign digit_tens = r_digits[7:4];
   assign digit_ones = r_digits[3:0];
   assign an         = r_an;
   assign seg        = r_seg;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Self-checking bench for bcd_display_ctrl: directed sequences, a vector table, and
// randomized traffic against a decimal-arithmetic reference model.
module tb_bcd_display_ctrl;

   localparam int IN_W = 14;
   localparam int SD   = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [IN_W-1:0] value = '0;
   logic            lz_blank = 1'b0;
   logic            busy, done, ovf;
   logic [3:0]      digit_thou, digit_hund, digit_tens, digit_ones, an;
   logic [6:0]      seg;

   always #5 clk = ~clk;

   bcd_display_ctrl #(.IN_W(IN_W), .SCAN_DIV(SD)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .value(value), .lz_blank(lz_blank),
      .busy(busy), .done(done), .ovf(ovf),
      .digit_thou(digit_thou), .digit_hund(digit_hund),
      .digit_tens(digit_tens), .digit_ones(digit_ones),
      .an(an), .seg(seg)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         10: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [10:0] disp(input int idx, input logic [15:0] d,
                                        input logic ov, input logic lz);
      int upper;
      logic [3:0] a;
      upper = int'(d) >> (4 * idx);
      a = 4'b1111;
      a[idx] = 1'b0;
      if (idx > 0 && lz && !ov && upper == 0) return {4'b1111, 7'b1111111};
      return {a, seg_of(upper % 16)};
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Reference model: m_rem = busy cycles left (done when 1); scan slot = (cycles since reset / SD) mod 4
   int          m_c, m_rem;
   logic [15:0] m_dig, m_pdig;
   logic        m_ovf, m_povf;
   logic [3:0]  m_an;
   logic [6:0]  m_seg;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_c <= 0; m_rem <= 0; m_dig <= '0; m_pdig <= '0;
         m_ovf <= 1'b0; m_povf <= 1'b0; m_an <= 4'b1111; m_seg <= 7'b1111111;
      end else begin
         m_c <= m_c + 1;
         {m_an, m_seg} <= disp((m_c / SD) % 4, m_dig, m_ovf, lz_blank);
         if (m_rem != 0) begin
            if (m_rem == 1) begin
               m_dig <= m_pdig;
               m_ovf <= m_povf;
            end
            m_rem <= m_rem - 1;
         end else if (start === 1'b1) begin
            if (int'(value) > 9999) begin
               m_rem <= 1; m_pdig <= 16'hAAAA; m_povf <= 1'b1;
            end else begin
               m_rem <= IN_W + 1; m_pdig <= to_bcd(int'(value)); m_povf <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("mdl_busy", busy, m_rem != 0);
      chk("mdl_done", done, m_rem == 1);
      chk("mdl_ovf", ovf, m_ovf);
      chk("mdl_digits", {digit_thou, digit_hund, digit_tens, digit_ones}, m_dig);
      chk("mdl_an", an, m_an);
      if (m_an != 4'b1111) chk("mdl_seg", seg, m_seg);
   end

   typedef struct {
      int          val;
      logic [15:0] exp_d;
      logic        exp_ovf;
      int          exp_lat;
   } vec_t;

   task automatic do_conv(input int v, output int lat);
      @(negedge clk);
      start = 1'b1;
      value = IN_W'(v);
      lat   = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      if (lat < 0) chk("conv_timeout", 0, 1);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int lat, cnt, seen_done;
      int c0, c1, c2, c3, cb;
      logic [3:0] ea[4];
      logic [6:0] es[4];
      logic [3:0] prev_an;
      logic synced;

      vecs[0] = '{0,     16'h0000, 1'b0, 15};
      vecs[1] = '{9999,  16'h9999, 1'b0, 15};
      vecs[2] = '{10000, 16'hAAAA, 1'b1, 1};
      vecs[3] = '{16383, 16'hAAAA, 1'b1, 1};
      vecs[4] = '{7,     16'h0007, 1'b0, 15};
      vecs[5] = '{8001,  16'h8001, 1'b0, 15};
      vecs[6] = '{1000,  16'h1000, 1'b0, 15};
      vecs[7] = '{5678,  16'h5678, 1'b0, 15};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_digits", {digit_thou, digit_hund, digit_tens, digit_ones}, 0);
      chk("rst_an", an, 4'b1111);
      chk("rst_seg", seg, 7'b1111111);
      #1 rst_n = 1'b1;

      // Conversion timing for 1234
      @(negedge clk);
      start = 1'b1;
      value = IN_W'(1234);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         start = 1'b0;
         chk($sformatf("t1234_busy_c%0d", k), busy, k <= 15);
         chk($sformatf("t1234_done_c%0d", k), done, k == 15);
      end
      chk("t1234_digits", {digit_thou, digit_hund, digit_tens, digit_ones}, 16'h1234);
      chk("t1234_ovf", ovf, 0);

      // Vector table
      for (int i = 0; i < 8; i++) begin
         do_conv(vecs[i].val, lat);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         @(negedge clk);
         chk($sformatf("vec%0d_digits", i), {digit_thou, digit_hund, digit_tens, digit_ones},
             vecs[i].exp_d);
         chk($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      end

      // Overflow: every scan slot shows a dash
      do_conv(10000, lat);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 16; k++) begin
         chk("ovf_seg_dash", seg, 7'b0111111);
         chk("ovf_an_lit", an != 4'b1111, 1);
         @(negedge clk);
      end

      // Leading-zero blanking with value 7
      lz_blank = 1'b1;
      do_conv(7, lat);
      repeat (2) @(negedge clk);
      c0 = 0; cb = 0;
      for (int k = 0; k < 16; k++) begin
         if (an == 4'b1110) begin
            c0++;
            chk("lz1_seg7", seg, 7'b1111000);
         end else begin
            cb++;
            chk("lz1_an_blank", an, 4'b1111);
         end
         @(negedge clk);
      end
      chk("lz1_ones_slots", c0, 4);
      chk("lz1_blank_slots", cb, 12);
      lz_blank = 1'b0;
      repeat (2) @(negedge clk);
      c0 = 0; c1 = 0; c2 = 0; c3 = 0;
      for (int k = 0; k < 16; k++) begin
         case (an)
            4'b1110: begin c0++; chk("lz0_seg_ones", seg, 7'b1111000); end
            4'b1101: begin c1++; chk("lz0_seg_tens", seg, 7'b1000000); end
            4'b1011: begin c2++; chk("lz0_seg_hund", seg, 7'b1000000); end
            4'b0111: begin c3++; chk("lz0_seg_thou", seg, 7'b1000000); end
            default: chk("lz0_an_valid", an, 4'b1110);
         endcase
         @(negedge clk);
      end
      chk("lz0_slot0", c0, 4);
      chk("lz0_slot1", c1, 4);
      chk("lz0_slot2", c2, 4);
      chk("lz0_slot3", c3, 4);

      // Scan order with digits 8,0,0,1
      do_conv(8001, lat);
      repeat (2) @(negedge clk);
      ea = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      es = '{7'b1111001, 7'b1000000, 7'b1000000, 7'b0000000};
      synced = 1'b0;
      prev_an = an;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (prev_an == 4'b0111 && an == 4'b1110) begin
            synced = 1'b1;
            break;
         end
         prev_an = an;
      end
      chk("scan_sync", synced, 1);
      if (synced) begin
         for (int s = 0; s < 4; s++) begin
            for (int r = 0; r < 4; r++) begin
               chk($sformatf("scan_an_s%0d", s), an, ea[s]);
               chk($sformatf("scan_seg_s%0d", s), seg, es[s]);
               @(negedge clk);
            end
         end
      end

      // start held high; value changes mid-conversion
      @(negedge clk);
      start = 1'b1;
      value = IN_W'(3210);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 5) value = IN_W'(42);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk("hold_lat", lat, 15);
      @(negedge clk);
      chk("hold_idle_gap", busy, 0);
      chk("hold_digits", {digit_thou, digit_hund, digit_tens, digit_ones}, 16'h3210);
      @(negedge clk);
      chk("hold_restart_busy", busy, 1);
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
      end
      chk("hold_second_lat", lat, 14);
      @(negedge clk);
      chk("hold_second_digits", {digit_thou, digit_hund, digit_tens, digit_ones}, 16'h0042);

      // Reset mid-conversion
      do_conv(1111, lat);
      @(negedge clk);
      chk("midrst_prev", {digit_thou, digit_hund, digit_tens, digit_ones}, 16'h1111);
      @(negedge clk);
      start = 1'b1;
      value = IN_W'(5678);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_digits", {digit_thou, digit_hund, digit_tens, digit_ones}, 0);
      chk("midrst_an", an, 4'b1111);
      @(negedge clk);
      #1 rst_n = 1'b1;
      seen_done = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen_done++;
      end
      chk("midrst_no_done", seen_done, 0);

      // Randomized traffic, including starts while busy and overflow values
      cnt = 0;
      for (int k = 0; k < 800; k++) begin
         @(negedge clk);
         start = ($urandom % 3 == 0);
         value = ($urandom % 4 == 0) ? IN_W'($urandom_range(9990, 16383))
                                     : IN_W'($urandom_range(0, 9999));
         if ($urandom % 64 == 0) lz_blank = ~lz_blank;
         if (done === 1'b1) cnt++;
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("rand_some_done", cnt > 10, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
Sequential controller between the calculator result register and the 4-digit 7-segment display. On a start strobe it converts a binary result to four BCD digits (thousands, hundreds, tens, ones) using multi-cycle shift-add-3 (double-dabble). It holds the converted digits and time-multiplexes them onto a common-segment display, with optional leading-zero blanking and an overflow indication.

Parameters:
IN_W, 14, width of the binary input; values 0..9999 are displayable.
SCAN_DIV, 100000, clk cycles per digit-scan step; minimum 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
value  input  IN_W  binary result; captured in the cycle start is accepted
lz_blank  input  1  1 = blank leading zeros; level-sensitive, read live
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits are committed
ovf  output  1  last committed conversion had value > 9999
digit_thou  output  4  committed thousands digit
digit_hund  output  4  committed hundreds digit
digit_tens  output  4  committed tens digit
digit_ones  output  4  committed ones digit
an  output  4  anode enables, active low; an[0] is the rightmost (ones) digit
seg  output  7  segments {g,f,e,d,c,b,a}, active low

Behaviour:
- Single clock, one asynchronous active-low reset. All state is reset by rst_n = 0 at any time, including mid-conversion.
- Reset values:
  - FSM = IDLE; busy = 0; done = 0; ovf = 0.
  - All digit outputs = 0; scan index = 0; prescaler = 0.
  - an = 4'b1111; seg = 7'b1111111.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE with start = 1: capture value.
    - If value > 9999: go to DONE with the overflow flag set.
    - Otherwise: clear the BCD shift register, load the bit counter with IN_W, and go to SHIFT.
  - IDLE with start = 0: stay in IDLE.
  - SHIFT, each cycle: every BCD nibble >= 5 gets +3, then the {BCD, binary} register shifts left by 1 and the counter decrements. After IN_W SHIFT cycles, go to DONE.
  - DONE, one cycle:
    - Commit the digits, set ovf to the overflow flag, pulse done = 1, go to IDLE.
    - On overflow, every committed digit is 4'hA (dash code).
- busy = 1 in SHIFT and DONE, 0 in IDLE.
- Latency, with start accepted in cycle 0:
  - Normal value: done is high in cycle IN_W+1 (cycle 15 for IN_W = 14).
  - Overflow value: done is high in cycle 1.
  - start may be reasserted in the cycle after done.
- start while busy is ignored; no queuing; the in-flight conversion is unaffected.
- Digit outputs and ovf change only in DONE, so the display never shows a partial result. They hold the last result indefinitely.
- Internal BCD register is 16 bits; add-3 is applied to all four nibbles in the same cycle.
- Scanner:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. At terminal count, the scan index advances 0→1→2→3→0 (0 = ones).
  - an and seg are registered and updated every cycle from the current scan index and committed digits, so display changes appear 1 cycle after commit or index change.
  - an = ~(1 << idx) unless the digit is blanked; then an = 4'b1111.
- Blanking rule: digit idx > 0 is blanked when lz_blank = 1, ovf = 0, and that digit and all higher digits are 0. The ones digit is never blanked.
- Segment decode, {g..a} active low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - A = 0111111 (dash)
  - B..F = 1111111
- The scanner runs independently of the FSM and is not stalled by conversions.

Test Plan:
- Conversion timing: IN_W = 14, start with value = 1234 in cycle 0 → busy = 1 in cycles 1..15; done = 1 in cycle 15 only; digits = 1,2,3,4 from cycle 16; ovf = 0.
- Boundary values:
  - value = 0 → digits 0,0,0,0, done in cycle 15.
  - value = 9999 → digits 9,9,9,9, ovf = 0.
  - value = 10000 → done in cycle 1; ovf = 1; all digits = 4'hA; with SCAN_DIV = 4, every scan slot shows seg = 0111111.
- start held high throughout a conversion with value changed to 42 mid-conversion → result is the originally captured value; a new conversion of 42 starts in the cycle after done.
- Leading-zero blanking: SCAN_DIV = 4, commit value = 7, lz_blank = 1 → an = 1110 with seg = 1111000 in slot 0; an = 1111 in slots 1..3. With lz_blank = 0, slots 1..3 show seg = 1000000 on an = 1101/1011/0111.
- Reset mid-operation: assert rst_n = 0 in cycle 6 of a conversion of 5678 (previous result 1111) → immediately busy = 0, done = 0, digits = 0, an = 1111. After release, no done pulse occurs until a new start.
- Scan order: SCAN_DIV = 4, digits 8,0,0,1, lz_blank = 0 → an cycles 1110, 1101, 1011, 0111, each held 4 cycles, with seg = 1111001, 1000000, 1000000, 0000000 respectively.
